l2big_control: RTL and testbench

- Controller that sequences the 8-way, 8-set, write-back L2 datapath (`L2big_datapath`).
- Services full-line requests from the L1/arbiter side and keeps one tree pseudo-LRU state per set.
- Drives all datapath selects and way-write strobes, plus the physical-memory read/write handshake.
- Sits between the L1 arbiter, `L2big_datapath` and physical memory.

---
 rtl/l2big_control.sv | 214 +++++++++++++++++++++
 tb/tb_l2big_control.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l2big_control.sv
// Control FSM for the 8-way, 8-set write-back L2: hit/miss sequencing,
// per-set tree pseudo-LRU, victim selection and physical-memory handshake.
module l2big_control #(
    parameter int INDEX_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [INDEX_WIDTH-1:0] index,
    input  logic [7:0]             Hit,
    input  logic [7:0]             Valid,
    input  logic [7:0]             Dirty,
    input  logic                   pmem_resp,
    output logic                   mem_resp,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic [7:0]             write,
    output logic                   valid_data,
    output logic                   dirty_data,
    output logic [7:0]             datainmux_sel,
    output logic                   pmem_address_mux_sel,
    output logic [2:0]             basemux_sel,
    output logic [2:0]             pmem_wdatamux_sel
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [6:0] plru_r [0:(2**INDEX_WIDTH)-1];
    logic [2:0] victim_r;
    logic [2:0] victim_s;
    logic [2:0] hit_way_s;
    logic       hit_s;
    logic       req_s;
    logic       plru_we_s;
    logic [2:0] plru_way_s;

    // Lowest-index set bit; 0 when the vector is empty.
    function automatic logic [2:0] first_set(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] plru_victim(input logic [6:0] b);
        logic       mid;
        logic       leaf;
        mid = b[0] ? b[2] : b[1];
        case ({b[0], mid})
            2'd0:    leaf = b[3];
            2'd1:    leaf = b[4];
            2'd2:    leaf = b[5];
            2'd3:    leaf = b[6];
            default: leaf = 1'b0;
        endcase
        return {b[0], mid, leaf};
    endfunction

    // Point every node on way w's path away from w.
    function automatic logic [6:0] plru_touch(input logic [6:0] b, input logic [2:0] w);
        logic [6:0] r;
        r = b;
        r[0] = ~w[2];
        if (w[2]) begin
            r[2] = ~w[1];
        end else begin
            r[1] = ~w[1];
        end
        case (w[2:1])
            2'd0:    r[3] = ~w[0];
            2'd1:    r[4] = ~w[0];
            2'd2:    r[5] = ~w[0];
            2'd3:    r[6] = ~w[0];
            default: r = b;
        endcase
        return r;
    endfunction

    assign hit_s     = |Hit;
    assign req_s     = mem_read | mem_write;
    assign hit_way_s = first_set(Hit);

    // State, latched victim and PLRU storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            victim_r <= 3'd0;
            for (int i = 0; i < 2**INDEX_WIDTH; i++) begin
                plru_r[i] <= 7'd0;
            end
        end else begin
            state_r <= state_s;
            if (state_r == CHECK && req_s && !hit_s) begin
                victim_r <= victim_s;
            end
            if (plru_we_s) begin
                plru_r[index] <= plru_touch(plru_r[index], plru_way_s);
            end
        end
    end

    // Next state, miss victim choice and PLRU update request.
    always_comb begin
        state_s    = state_r;
        plru_we_s  = 1'b0;
        plru_way_s = 3'd0;
        if (&Valid) begin
            victim_s = plru_victim(plru_r[index]);
        end else begin
            victim_s = first_set(~Valid);
        end
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_s = CHECK;
                end else begin
                    state_s = IDLE;
                end
            end
            CHECK: begin
                if (!req_s) begin
                    state_s = IDLE;
                end else if (hit_s) begin
                    state_s    = IDLE;
                    plru_we_s  = 1'b1;
                    plru_way_s = hit_way_s;
                end else if (Valid[victim_s] && Dirty[victim_s]) begin
                    state_s = WRITEBACK;
                end else begin
                    state_s = ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    state_s = ALLOCATE;
                end else begin
                    state_s = WRITEBACK;
                end
            end
            ALLOCATE: begin
                if (pmem_resp) begin
                    state_s    = CHECK;
                    plru_we_s  = 1'b1;
                    plru_way_s = victim_r;
                end else begin
                    state_s = ALLOCATE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Output decode from state, latched victim and hit vector.
    always_comb begin
        mem_resp             = 1'b0;
        pmem_read            = 1'b0;
        pmem_write           = 1'b0;
        write                = 8'd0;
        valid_data           = 1'b0;
        dirty_data           = 1'b0;
        datainmux_sel        = 8'd0;
        pmem_address_mux_sel = 1'b0;
        basemux_sel          = 3'd0;
        pmem_wdatamux_sel    = 3'd0;
        case (state_r)
            CHECK: begin
                if (req_s && hit_s) begin
                    mem_resp = 1'b1;
                    if (mem_write) begin
                        write         = 8'd1 << hit_way_s;
                        datainmux_sel = 8'd1 << hit_way_s;
                        valid_data    = 1'b1;
                        dirty_data    = 1'b1;
                    end else begin
                        write = 8'd0;
                    end
                end else begin
                    mem_resp = 1'b0;
                end
            end
            WRITEBACK: begin
                pmem_write           = 1'b1;
                pmem_address_mux_sel = 1'b1;
                basemux_sel          = victim_r;
                pmem_wdatamux_sel    = victim_r;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    write      = 8'd1 << victim_r;
                    valid_data = 1'b1;
                end else begin
                    write = 8'd0;
                end
            end
            default: begin
                mem_resp = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_l2big_control.sv
// Scoreboard bench for l2big_control: the bench plays arbiter, datapath and
// physical memory; a monitor compares every new non-idle output pattern.
module tb_l2big_control;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] index;
    logic [7:0] Hit;
    logic [7:0] Valid;
    logic [7:0] Dirty;
    logic       pmem_resp;
    logic       mem_resp;
    logic       pmem_read;
    logic       pmem_write;
    logic [7:0] write;
    logic       valid_data;
    logic       dirty_data;
    logic [7:0] datainmux_sel;
    logic       pmem_address_mux_sel;
    logic [2:0] basemux_sel;
    logic [2:0] pmem_wdatamux_sel;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [27:0] exp_q[$];
    int          resp_cyc[$];
    logic [27:0] prev_out = 28'd0;

    l2big_control #(.INDEX_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .index(index), .Hit(Hit), .Valid(Valid), .Dirty(Dirty),
        .pmem_resp(pmem_resp), .mem_resp(mem_resp), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .write(write), .valid_data(valid_data),
        .dirty_data(dirty_data), .datainmux_sel(datainmux_sel),
        .pmem_address_mux_sel(pmem_address_mux_sel), .basemux_sel(basemux_sel),
        .pmem_wdatamux_sel(pmem_wdatamux_sel)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] outs_now();
        return {mem_resp, pmem_read, pmem_write, write, valid_data, dirty_data,
                datainmux_sel, pmem_address_mux_sel, basemux_sel, pmem_wdatamux_sel};
    endfunction

    function automatic logic [27:0] vec(input logic mr, input logic pr, input logic pw,
                                        input logic [7:0] wr, input logic vd, input logic dd,
                                        input logic [7:0] dm, input logic as,
                                        input logic [2:0] bm, input logic [2:0] wm);
        return {mr, pr, pw, wr, vd, dd, dm, as, bm, wm};
    endfunction

    function automatic logic [27:0] v_rhit();
        return vec(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 3'd0);
    endfunction
    function automatic logic [27:0] v_whit(input logic [2:0] w);
        return vec(1'b1, 1'b0, 1'b0, 8'd1 << w, 1'b1, 1'b1, 8'd1 << w, 1'b0, 3'd0, 3'd0);
    endfunction
    function automatic logic [27:0] v_alloc();
        return vec(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 3'd0);
    endfunction
    function automatic logic [27:0] v_fill(input logic [2:0] w);
        return vec(1'b0, 1'b1, 1'b0, 8'd1 << w, 1'b1, 1'b0, 8'd0, 1'b0, 3'd0, 3'd0);
    endfunction
    function automatic logic [27:0] v_wb(input logic [2:0] w);
        return vec(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, w, w);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read or write hit: request seen in IDLE, response in the CHECK cycle.
    task automatic hit_req(input logic rd, input logic [2:0] idx, input logic [2:0] way);
        mem_read  = rd;
        mem_write = ~rd;
        index     = idx;
        Hit       = 8'd1 << way;
        Valid     = 8'hFF;
        Dirty     = 8'h00;
        exp_q.push_back(rd ? v_rhit() : v_whit(way));
        tick();
        tick();
    endtask

    task automatic idle_req();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        Hit       = 8'd0;
    endtask

    // Miss with optional writeback, fill, then the completing CHECK hit.
    task automatic miss_req(input logic rd, input logic [2:0] idx, input logic [7:0] vld,
                            input logic [7:0] drt, input logic [2:0] vic, input logic wb);
        mem_read  = rd;
        mem_write = ~rd;
        index     = idx;
        Hit       = 8'd0;
        Valid     = vld;
        Dirty     = drt;
        tick();
        if (wb) begin
            exp_q.push_back(v_wb(vic));
            tick();
            tick();
            pmem_resp = 1'b1;
        end
        exp_q.push_back(v_alloc());
        tick();
        pmem_resp = 1'b0;
        tick();
        pmem_resp = 1'b1;
        Hit       = 8'd1 << vic;
        exp_q.push_back(v_fill(vic));
        tick();
        pmem_resp = 1'b0;
        exp_q.push_back(rd ? v_rhit() : v_whit(vic));
        tick();
        idle_req();
    endtask

    initial begin
        reset     = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        index     = 3'd0;
        Hit       = 8'd0;
        Valid     = 8'd0;
        Dirty     = 8'd0;
        pmem_resp = 1'b0;

        fork
            forever begin
                logic [27:0] cur;
                logic [27:0] want;
                @(negedge clk);
                cyc++;
                cur = outs_now();
                if (!reset && cur != 28'd0 && cur != prev_out) begin
                    if (cur[27]) resp_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output got %h want none", cur);
                    end else begin
                        want = exp_q.pop_front();
                        chk("monitor_outputs", {4'd0, cur}, {4'd0, want});
                    end
                end
                prev_out = cur;
            end
            begin
                #200000;
                $display("FAIL watchdog got timeout want finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        tick();
        tick();
        begin
            logic [6:0] acc;
            acc = 7'd0;
            for (int i = 0; i < 8; i++) acc = acc | dut.plru_r[i];
            chk("reset_outputs", {4'd0, outs_now()}, 32'd0);
            chk("reset_plru", {25'd0, acc}, 32'd0);
        end
        reset = 1'b0;

        // Cold read to set 3: invalid way 0 is filled.
        miss_req(1'b1, 3'd3, 8'h00, 8'h00, 3'd0, 1'b0);
        chk("plru3_cold", {25'd0, dut.plru_r[3]}, {25'd0, 7'b0001011});

        // Write hit way 5 in set 3.
        hit_req(1'b0, 3'd3, 3'd5);
        idle_req();
        chk("plru3_whit5", {25'd0, dut.plru_r[3]}, {25'd0, 7'b0001110});

        // Full set 1, PLRU 0, dirty victim way 0.
        miss_req(1'b1, 3'd1, 8'hFF, 8'h01, 3'd0, 1'b1);
        chk("plru1_wb", {25'd0, dut.plru_r[1]}, {25'd0, 7'b0001011});

        // Touch 0,4,2,6 in set 2, then a clean miss must pick way 1.
        hit_req(1'b1, 3'd2, 3'd0);
        hit_req(1'b1, 3'd2, 3'd4);
        hit_req(1'b1, 3'd2, 3'd2);
        hit_req(1'b1, 3'd2, 3'd6);
        idle_req();
        chk("plru2_seq", {25'd0, dut.plru_r[2]}, {25'd0, 7'b1001000 | 7'b0111000 & 7'b1111000});
        miss_req(1'b1, 3'd2, 8'hFF, 8'h00, 3'd1, 1'b0);
        chk("plru2_fill1", {25'd0, dut.plru_r[2]}, {25'd0, 7'b1110011});

        // Back-to-back read hits to sets 4 and 5.
        resp_cyc.delete();
        hit_req(1'b1, 3'd4, 3'd3);
        hit_req(1'b1, 3'd5, 3'd6);
        idle_req();
        tick();
        chk("b2b_count", resp_cyc.size(), 32'd2);
        if (resp_cyc.size() == 2) chk("b2b_gap", resp_cyc[1] - resp_cyc[0], 32'd2);
        chk("plru4", {25'd0, dut.plru_r[4]}, {25'd0, 7'b0000001});
        chk("plru5", {25'd0, dut.plru_r[5]}, {25'd0, 7'b1000000});
        chk("plru3_kept", {25'd0, dut.plru_r[3]}, {25'd0, 7'b0001110});

        // Reset while writing back set 6's dirty way 0.
        mem_read = 1'b1;
        index    = 3'd6;
        Hit      = 8'd0;
        Valid    = 8'hFF;
        Dirty    = 8'hFF;
        tick();
        exp_q.push_back(v_wb(3'd0));
        tick();
        tick();
        chk("wb_before_reset", {31'd0, pmem_write}, 32'd1);
        reset = 1'b1;
        idle_req();
        tick();
        begin
            logic [6:0] acc;
            acc = 7'd0;
            for (int i = 0; i < 8; i++) acc = acc | dut.plru_r[i];
            chk("midreset_outputs", {4'd0, outs_now()}, 32'd0);
            chk("midreset_plru", {25'd0, acc}, 32'd0);
        end
        reset = 1'b0;
        tick();
        tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
